// File: rtl/alu_issue_stage.sv
// Operand-issue and write-back stage around a 32-bit, two-cycle registered ALU.
// Owns a 4x32 register file, issues one operation at a time, writes back the
// result and captures the ALU flags; captured carry feeds the next carry-in.
//
// Request handshake: a request transfers on a rising edge where
// req_valid & req_ready. req_ready depends only on the FSM state (high in
// IDLE). While busy, req_valid is ignored and the requester must hold it.
module alu_issue_stage (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_funsel,
  input  logic [1:0]  req_src_a,
  input  logic [1:0]  req_src_b,
  input  logic        req_imm_sel,
  input  logic [31:0] req_imm,
  input  logic [1:0]  req_dst,
  input  logic        req_wb_en,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [4:0]  alu_funsel,
  output logic        alu_cin,
  input  logic [31:0] alu_out,
  input  logic [3:0]  alu_flags,
  output logic        done,
  output logic [3:0]  flags_q,
  input  logic [1:0]  rd_sel,
  output logic [31:0] rd_data,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    S_OP  = 2'd1,
    S_OUT = 2'd2,
    S_FLG = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        accept;
  logic        wb_fire;
  logic        flg_fire;
  logic [1:0]  dst_q;
  logic        wb_en_q;
  logic [31:0] opnd_b;
  logic [31:0] regs [4];

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: one fixed walk IDLE -> S_OP -> S_OUT -> S_FLG -> IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid) state_next = S_OP;
      S_OP:    state_next = S_OUT;
      S_OUT:   state_next = S_FLG;
      S_FLG:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Decoded controls, all from the current state.
  always_comb begin
    req_ready = (state == IDLE);
    accept    = req_valid & (state == IDLE);
    wb_fire   = (state == S_OUT) & wb_en_q;
    flg_fire  = (state == S_FLG);
    state_dbg = state;
  end

  // Operand B source select.
  always_comb begin
    opnd_b = req_imm_sel ? req_imm : regs[req_src_b];
  end

  // ALU input registers and retained destination; they only move on accept,
  // so the ALU sees stable inputs for the whole operation and while idle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      alu_a      <= 32'd0;
      alu_b      <= 32'd0;
      alu_funsel <= 5'd0;
      alu_cin    <= 1'b0;
      dst_q      <= 2'd0;
      wb_en_q    <= 1'b0;
    end else if (accept) begin
      alu_a      <= regs[req_src_a];
      alu_b      <= opnd_b;
      alu_funsel <= req_funsel;
      alu_cin    <= flags_q[2];
      dst_q      <= req_dst;
      wb_en_q    <= req_wb_en;
    end
  end

  // Register file write-back of the full 32-bit ALU result.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) regs[i] <= 32'd0;
    end else if (wb_fire) begin
      regs[dst_q] <= alu_out;
    end
  end

  // Flag capture and the retire pulse, both on leaving S_FLG.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      flags_q <= 4'd0;
      done    <= 1'b0;
    end else begin
      done <= flg_fire;
      if (flg_fire) flags_q <= alu_flags;
    end
  end

  // Debug read port, combinational.
  always_comb begin
    rd_data = regs[rd_sel];
  end

endmodule
